// File: rtl/cpu_seq_pkg.sv
// -----------------------------------------------------------------------------
// cpu_seq_pkg
// Shared types and constants for the multi-cycle RV32I sequencing controller.
//   seq_state_t   : FSM state encoding. The values are visible on the debug
//                   'state' port, so they must not be renumbered.
//   OP_*          : the nine RV32I major opcodes the core accepts.
//   TC_*          : trap_cause codes.
//   op_is_legal() : returns 1 when a 7-bit major opcode is one of OP_*.
// -----------------------------------------------------------------------------
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } seq_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] TC_NONE    = 2'b00;
    localparam logic [1:0] TC_ILLEGAL = 2'b01;
    localparam logic [1:0] TC_IBUS    = 2'b10;
    localparam logic [1:0] TC_DBUS    = 2'b11;

    function automatic logic op_is_legal(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// -----------------------------------------------------------------------------
// bus_timeout_cnt
// Counts the wait cycles of one outstanding bus request and flags expiry.
// Ports:
//   clk, rst  : clock and asynchronous active-low reset.
//   req       : a request is outstanding this cycle.
//   ack       : the request completes this cycle.
//   clr       : the owning FSM changes state this cycle; restart the count.
//   limit     : number of request cycles allowed; 0 disables expiry.
//   expired   : combinational; high in the request cycle that reaches limit.
//               Held low when ack is present, so a late ack always wins.
// -----------------------------------------------------------------------------
module bus_timeout_cnt #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            ack,
    input  logic            clr,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);

    logic [TO_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || ack || !req) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + TO_W'(1);
        end
    end

    // cnt_reg holds the number of completed wait cycles, so the current cycle
    // is request cycle cnt_reg+1. Expire when that reaches the limit.
    assign expired = (limit != '0) && req && !ack && (cnt_reg == limit - TO_W'(1));

endmodule

// File: rtl/cpu_core_seq.sv
// -----------------------------------------------------------------------------
// cpu_core_seq
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core. Owns the
// instruction register and produces per-stage strobes for the datapath.
// Instruction and data memories use req/ack handshakes with arbitrary waits,
// guarded by a request timeout that traps the core.
//
// Optional feature: define CPU_CORE_SEQ_PERF_EN to add the cyc_cnt and
// instret_cnt performance counters (and their output ports).
//
// Ports:
//   clk         : core clock, rising edge.
//   rst         : asynchronous, active-low reset.
//   halt        : hold the core in IDLE before the next fetch.
//   i_req/i_ack : instruction fetch handshake; iData valid with i_ack.
//   ir          : latched instruction register.
//   d_req/d_ack : data memory handshake; d_wr_en marks stores.
//   ld_en       : latch load data into the datapath load register.
//   reg_wr_en   : register file write strobe.
//   pc_en       : PC update strobe.
//   trap        : sticky fault indicator (core is in TRAP).
//   trap_cause  : 00 none, 01 illegal opcode, 10 i-bus timeout, 11 d-bus timeout.
//   state       : current FSM state, for debug.
//   cyc_cnt, instret_cnt : performance counters (CPU_CORE_SEQ_PERF_EN only).
// -----------------------------------------------------------------------------
module cpu_core_seq
    import cpu_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    output logic            i_req,
    input  logic            i_ack,
    input  logic [XLEN-1:0] iData,
    output logic [XLEN-1:0] ir,
    output logic            d_req,
    output logic            d_wr_en,
    input  logic            d_ack,
    output logic            ld_en,
    output logic            reg_wr_en,
    output logic            pc_en,
    output logic            trap,
    output logic [1:0]      trap_cause,
    output logic [2:0]      state
`ifdef CPU_CORE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    seq_state_t      state_reg, state_next;
    logic [1:0]      cause_reg, cause_next;
    logic [XLEN-1:0] ir_reg;
    logic [6:0]      opcode;
    logic            is_load, is_store, is_branch;
    logic            to_ack, to_clr, to_expired;

    assign opcode    = ir_reg[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cause_reg <= TC_NONE;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (state_reg == S_FETCH && i_ack) begin
                ir_reg <= iData;
            end
        end
    end

    // ------------------------------------------------- next state / strobes
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        i_req      = 1'b0;
        d_req      = 1'b0;
        d_wr_en    = 1'b0;
        ld_en      = 1'b0;
        reg_wr_en  = 1'b0;
        pc_en      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!halt) state_next = S_FETCH;
            end
            S_FETCH: begin
                i_req = 1'b1;
                // ack takes priority over a same-cycle expiry
                if (i_ack) begin
                    state_next = S_DECODE;
                end else if (to_expired) begin
                    state_next = S_TRAP;
                    cause_next = TC_IBUS;
                end
            end
            S_DECODE: begin
                if (!op_is_legal(opcode)) begin
                    state_next = S_TRAP;
                    cause_next = TC_ILLEGAL;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_en      = 1'b1;
                    state_next = S_IDLE;
                end else if (is_load || is_store) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                d_req   = 1'b1;
                d_wr_en = is_store;
                if (d_ack) begin
                    if (is_store) begin
                        pc_en      = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        ld_en      = 1'b1;
                        state_next = S_WB;
                    end
                end else if (to_expired) begin
                    state_next = S_TRAP;
                    cause_next = TC_DBUS;
                end
            end
            S_WB: begin
                reg_wr_en  = 1'b1;
                pc_en      = 1'b1;
                state_next = S_IDLE;
            end
            S_TRAP: begin
                // absorbing: only reset leaves TRAP
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- bus timeout
    // One counter serves both buses; at most one request is ever outstanding.
    assign to_ack = ((state_reg == S_FETCH) && i_ack) || ((state_reg == S_MEM) && d_ack);
    assign to_clr = (state_next != state_reg);

    bus_timeout_cnt #(
        .TO_W (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .req     (i_req | d_req),
        .ack     (to_ack),
        .clr     (to_clr),
        .limit   (TO_LIMIT),
        .expired (to_expired)
    );

    assign ir         = ir_reg;
    assign trap       = (state_reg == S_TRAP);
    assign trap_cause = cause_reg;
    assign state      = state_reg;

`ifdef CPU_CORE_SEQ_PERF_EN
    // ---------------------------------------------------- perf counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt     <= '0;
            instret_cnt <= '0;
        end else begin
            if (!((state_reg == S_IDLE) && halt) && (state_reg != S_TRAP)) begin
                cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
            if (pc_en) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cpu_core_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_core_seq
// Directed bench for cpu_core_seq (TIMEOUT_CYC=4). Each cycle's observation is
// packed as {state[2:0], i_req, d_req, d_wr_en, ld_en, reg_wr_en, pc_en} and
// compared with a hand-written per-cycle table. Inputs change on the falling
// edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_cpu_core_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b1;
    logic        i_ack = 1'b0;
    logic        d_ack = 1'b0;
    logic [31:0] iData = 32'h0;
    logic        i_req, d_req, d_wr_en, ld_en, reg_wr_en, pc_en, trap;
    logic [31:0] ir;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
`ifdef CPU_CORE_SEQ_PERF_EN
    logic [31:0] cyc_cnt, instret_cnt;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cpu_core_seq #(
        .XLEN        (32),
        .TIMEOUT_CYC (4),
        .TO_W        (8),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .i_req       (i_req),
        .i_ack       (i_ack),
        .iData       (iData),
        .ir          (ir),
        .d_req       (d_req),
        .d_wr_en     (d_wr_en),
        .d_ack       (d_ack),
        .ld_en       (ld_en),
        .reg_wr_en   (reg_wr_en),
        .pc_en       (pc_en),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .state       (state)
`ifdef CPU_CORE_SEQ_PERF_EN
        ,
        .cyc_cnt     (cyc_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    function automatic logic [8:0] snap();
        return {state, i_req, d_req, d_wr_en, ld_en, reg_wr_en, pc_en};
    endfunction

    // Hold reset for two rising edges with halt set, then release on a falling edge.
    task automatic do_reset();
        rst = 1'b0; halt = 1'b1; i_ack = 1'b0; d_ack = 1'b0; iData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; halt = 1'b0; i_ack = 1'b1; iData = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (snap() !== 9'b000_000000) begin
            errors++; $display("FAIL reset_strobes: got %b want %b", snap(), 9'b000_000000);
        end
        vectors++;
        if ({ir, trap, trap_cause} !== 35'h0) begin
            errors++; $display("FAIL reset_regs: got ir=%h trap=%b cause=%b want 0", ir, trap, trap_cause);
        end
        $display("test_reset: done");
    endtask

    task automatic test_alu();
        logic [8:0] exp_v [0:5];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b010_000000,
                  9'b011_000000, 9'b101_000011, 9'b000_000000};
        do_reset();
        iData = 32'h002081B3;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = 1'b1; d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL alu_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
            if (k == 2) begin
                vectors++;
                if (ir !== 32'h002081B3) begin
                    errors++; $display("FAIL alu_ir: got %h want %h", ir, 32'h002081B3);
                end
            end
        end
        $display("test_alu: ADD sequenced");
    endtask

    task automatic test_load_wait();
        logic [8:0] exp_v [0:9];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b010_000000, 9'b011_000000,
                  9'b100_010000, 9'b100_010000, 9'b100_010000, 9'b100_010100,
                  9'b101_000011, 9'b000_000000};
        do_reset();
        iData = 32'h00012083;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = 1'b1; d_ack = (k == 7);
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL load_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        $display("test_load_wait: LW with 3 wait cycles");
    endtask

    task automatic test_store_wait();
        logic [8:0] exp_v [0:6];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b010_000000, 9'b011_000000,
                  9'b100_011000, 9'b100_011001, 9'b000_000000};
        do_reset();
        iData = 32'h0020A023;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = 1'b1; d_ack = (k == 5);
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL store_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        $display("test_store_wait: SW with 1 wait cycle");
    endtask

    task automatic test_branch();
        logic [8:0] exp_v [0:4];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b010_000000,
                  9'b011_000001, 9'b000_000000};
        do_reset();
        iData = 32'h00208463;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = 1'b1; d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL branch_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        $display("test_branch: BEQ sequenced");
    endtask

    task automatic test_illegal();
        logic [8:0] exp_v [0:5];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b010_000000,
                  9'b110_000000, 9'b110_000000, 9'b110_000000};
        do_reset();
        iData = 32'h0000007F;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            halt = 1'b0; i_ack = 1'b1; d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL illegal_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        vectors++;
        if ({trap, trap_cause} !== 3'b1_01) begin
            errors++; $display("FAIL illegal_cause: got trap=%b cause=%b want 1/01", trap, trap_cause);
        end
        rst = 1'b0; #1;
        vectors++;
        if ({state, trap, trap_cause} !== 6'b000_0_00) begin
            errors++; $display("FAIL illegal_clear: got state=%0d trap=%b cause=%b want 0/0/00",
                               state, trap, trap_cause);
        end
        $display("test_illegal: trap 01 and reset clear");
    endtask

    task automatic test_timeout_ifetch();
        logic [8:0] exp_v [0:5];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b001_100000,
                  9'b001_100000, 9'b001_100000, 9'b110_000000};
        do_reset();
        iData = 32'h002081B3;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = 1'b0; d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL ito_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        vectors++;
        if ({trap, trap_cause} !== 3'b1_10) begin
            errors++; $display("FAIL ito_cause: got trap=%b cause=%b want 1/10", trap, trap_cause);
        end
        $display("test_timeout_ifetch: trap 10 after 4 request cycles");
    endtask

    task automatic test_timeout_ack_wins();
        logic [8:0] exp_v [0:7];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b001_100000, 9'b001_100000,
                  9'b001_100000, 9'b010_000000, 9'b011_000000, 9'b101_000011};
        do_reset();
        iData = 32'h002081B3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = (k == 4); d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL ackwin_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
            if (k == 5) begin
                vectors++;
                if ({trap, trap_cause} !== 3'b0_00) begin
                    errors++; $display("FAIL ackwin_notrap: got trap=%b cause=%b want 0/00", trap, trap_cause);
                end
            end
        end
        $display("test_timeout_ack_wins: ack on expiry cycle");
    endtask

    task automatic test_timeout_dbus();
        logic [8:0] exp_v [0:8];
        exp_v = '{9'b000_000000, 9'b001_100000, 9'b010_000000, 9'b011_000000,
                  9'b100_010000, 9'b100_010000, 9'b100_010000, 9'b100_010000,
                  9'b110_000000};
        do_reset();
        iData = 32'h00012083;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            halt = (k != 0); i_ack = 1'b1; d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL dto_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        vectors++;
        if ({trap, trap_cause} !== 3'b1_11) begin
            errors++; $display("FAIL dto_cause: got trap=%b cause=%b want 1/11", trap, trap_cause);
        end
        $display("test_timeout_dbus: trap 11 after 4 data request cycles");
    endtask

    task automatic test_halt();
        logic [8:0] exp_v [0:4];
        exp_v = '{9'b000_000000, 9'b000_000000, 9'b000_000000,
                  9'b000_000000, 9'b001_100000};
        do_reset();
        iData = 32'h002081B3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            halt = (k < 3); i_ack = 1'b0; d_ack = 1'b0;
            #1;
            vectors++;
            if (snap() !== exp_v[k]) begin
                errors++; $display("FAIL halt_cyc%0d: got %b want %b", k, snap(), exp_v[k]);
            end
        end
        $display("test_halt: fetch starts after halt release");
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        @(negedge clk); halt = 1'b0;
        @(negedge clk); #1;
        vectors++;
        if ({state, i_req} !== 4'b001_1) begin
            errors++; $display("FAIL midrst_fetch: got state=%0d i_req=%b want 1/1", state, i_req);
        end
        rst = 1'b0; #1;
        vectors++;
        if ({state, i_req} !== 4'b000_0) begin
            errors++; $display("FAIL midrst_drop: got state=%0d i_req=%b want 0/0", state, i_req);
        end
        $display("test_reset_mid_access: async reset drops i_req");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_store_wait();
        test_branch();
        test_illegal();
        test_timeout_ifetch();
        test_timeout_ack_wins();
        test_timeout_dbus();
        test_halt();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cpu_core_seq.md
Name: cpu_core_seq

Overview:
- Multi-cycle sequencing controller for the next-generation RV32I core. It replaces single-cycle operation with a FETCH/DECODE/EXECUTE/MEM/WB state machine.
- Talks to instruction and data memories through req/ack handshakes with wait states, so slow or shared memory can be used.
- Latches the instruction and produces per-stage enables (PC, IR, register-file write, data-memory access) for the datapath. The existing control_unit still decodes ALU and mux selects.
- Sits between the memories and datapath, inside the core top.

Parameters:
- XLEN, 32, instruction/data width; only the low 7 bits of ir are decoded.
- TIMEOUT_CYC, 16, max cycles a req may wait for ack before trap; 0 disables the timeout.
- TO_W, 8, timeout counter width; TIMEOUT_CYC must be < 2**TO_W.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- halt  in  1  hold the core before the next fetch.
- i_req  out  1  instruction fetch request.
- i_ack  in  1  fetch data valid on iData this cycle.
- iData  in  XLEN  fetched instruction.
- ir  out  XLEN  latched instruction register.
- d_req  out  1  data memory request.
- d_wr_en  out  1  store qualifier for d_req.
- d_ack  in  1  data access complete; load data valid.
- ld_en  out  1  latch dRdata into the datapath load register.
- reg_wr_en  out  1  register file write strobe.
- pc_en  out  1  PC update strobe.
- trap  out  1  sticky fault indicator.
- trap_cause  out  2  00 none, 01 illegal opcode, 10 i-bus timeout, 11 d-bus timeout.
- state  out  3  current FSM state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. State is registered; outputs are combinational from state and acks.
- Reset (rst=0): state=IDLE; ir=0; trap=0; trap_cause=00; timeout counter=0. All strobes (i_req, d_req, d_wr_en, ld_en, reg_wr_en, pc_en) are 0 in IDLE.
- IDLE: if halt=0, go to FETCH next cycle; otherwise stay.
- FETCH:
  - i_req=1 every cycle.
  - On i_ack=1, load ir<=iData and go to DECODE.
  - halt does not abort an outstanding fetch.
- DECODE: 1 cycle with no strobes. Illegal opcode goes to TRAP with cause 01; otherwise go to EXEC.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
- EXEC: 1 cycle.
  - Branch (1100011): pc_en=1, then IDLE.
  - Load or store: go to MEM.
  - Others: go to WB.
- MEM:
  - d_req=1 every cycle; d_wr_en=1 only for stores.
  - On d_ack for a load: ld_en=1 in the same cycle, then WB.
  - On d_ack for a store: pc_en=1 in the same cycle, then IDLE.
- WB: reg_wr_en=1 and pc_en=1 for exactly 1 cycle, then IDLE.
- Latency with zero-wait acks (excluding IDLE):
  - ALU/JAL/JALR/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds 1.
- Timeout:
  - The counter increments every cycle req is high and ack is low, and clears on ack or state change.
  - When it equals TIMEOUT_CYC (with TIMEOUT_CYC≠0), go to TRAP with cause 10 (FETCH) or 11 (MEM).
  - If ack arrives in the expiry cycle, ack wins and no trap is raised.
- TRAP: absorbing until reset. All strobes are 0; trap=1; trap_cause is held. pc_en is never asserted, so architectural state is frozen.
- halt is sampled only in IDLE.
- Reset mid-access drops i_req/d_req asynchronously. Memories must tolerate an abandoned request.

Optional Feature:
- Macro CPU_CORE_SEQ_PERF_EN.
- Defined: adds outputs cyc_cnt and instret_cnt, both CNT_W wide, reset to 0.
  - cyc_cnt increments every cycle the state is not IDLE-with-halt and not TRAP.
  - instret_cnt increments on every pc_en.
  - Both wrap modulo 2**CNT_W.
- Undefined: no counter ports and no counter logic.

Decomposition:
- Package cpu_seq_pkg contains:
  - typedef enum logic [2:0] seq_state_t;
  - opcode localparams OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - trap_cause localparams.
- One sub-module, bus_timeout_cnt, parameterised by TO_W. Inputs: req, ack, clr, limit. Output: expired.

Test Plan:
- Zero-wait ADD (iData=32'h002081B3, i_ack tied 1): ir updated on the first FETCH edge; reg_wr_en and pc_en high exactly 1 cycle, 4 cycles after leaving IDLE.
- LW with d_ack delayed 3 cycles: d_req high 4 cycles, d_wr_en=0, ld_en pulses with d_ack, then a 1-cycle WB; 8 cycles total.
- SW with d_ack delayed 1 cycle: d_wr_en=1 for both MEM cycles; pc_en pulses with d_ack; reg_wr_en never asserts.
- BEQ (32'h00208463): pc_en at EXEC, 3 cycles total; no reg_wr_en or d_req.
- Illegal opcode 32'h0000007F: TRAP after DECODE, trap_cause=01, no further i_req; only rst=0 clears it.
- Timeout with TIMEOUT_CYC=4 and i_ack held 0:
  - trap_cause=10 after 4 request cycles.
  - Repeat with i_ack=1 on the 4th cycle: no trap, DECODE entered.
- With halt=1 in IDLE: no i_req; deassert halt and fetch begins the next cycle.
